// File: rtl/ctrl_pkg.sv
// ctrl_pkg: RV32I opcodes, control encodings, the per-stage control word and the bubble constant.
package ctrl_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_BR  = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef struct packed {
        logic       alu_src;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       regwrite;
        logic [1:0] wb_sel;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    function automatic logic reads_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction
endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: ID-stage inputs and per-stage control outputs of pipe_ctrl_unit.
interface pipe_ctrl_unit_if #(
    parameter int OPC_W   = 7,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 2
);
    logic               id_valid;
    logic [OPC_W-1:0]   id_opcode;
    logic [RA_W-1:0]    id_rs1;
    logic [RA_W-1:0]    id_rs2;
    logic [RA_W-1:0]    id_rd;
    logic               flush;
    logic               ex_alu_src;
    logic [ALUOP_W-1:0] ex_alu_op;
    logic [RA_W-1:0]    ex_rd;
    logic               mem_read;
    logic               mem_write;
    logic               mem_branch;
    logic               mem_jump;
    logic               wb_regwrite;
    logic [1:0]         wb_sel;
    logic [RA_W-1:0]    wb_rd;
    logic               stall;
    logic               ex_illegal;

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        output ex_alu_src, ex_alu_op, ex_rd, mem_read, mem_write, mem_branch, mem_jump,
               wb_regwrite, wb_sel, wb_rd, stall, ex_illegal
    );

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, flush,
        input  ex_alu_src, ex_alu_op, ex_rd, mem_read, mem_write, mem_branch, mem_jump,
               wb_regwrite, wb_sel, wb_rd, stall, ex_illegal
    );
endinterface

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational RV32I opcode decode into a control word; invalid slots and x0 writes are neutralised.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 7,
    parameter int RA_W  = 5
) (
    input  logic             valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [RA_W-1:0]  rd,
    output ctrl_t            ctrl,
    output logic [RA_W-1:0]  ctrl_rd
);
    logic [6:0] op;

    assign op = 7'(opcode);

    always_comb begin
        ctrl = BUBBLE;
        if (valid) begin
            case (op)
                OP_R:      begin ctrl.alu_op = ALU_FN; ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_ALU; end
                OP_I:      begin ctrl.alu_op = ALU_FN; ctrl.alu_src = 1'b1; ctrl.regwrite = 1'b1; end
                OP_LOAD:   begin ctrl.alu_op = ALU_ADD; ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_MEM; end
                OP_STORE:  begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
                OP_BRANCH: begin ctrl.alu_op = ALU_BR; ctrl.branch = 1'b1; end
                OP_JAL:    begin ctrl.jump = 1'b1; ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_PC4; end
                OP_JALR:   begin ctrl.alu_src = 1'b1; ctrl.jump = 1'b1; ctrl.regwrite = 1'b1; ctrl.wb_sel = WB_PC4; end
                OP_LUI, OP_AUIPC: begin ctrl.alu_src = 1'b1; ctrl.regwrite = 1'b1; end
                default:   ctrl.illegal = 1'b1;
            endcase
            ctrl.regwrite = ctrl.regwrite && (rd != '0);
        end
    end

    // an illegal opcode travels as a bubble, so it carries no destination either
    assign ctrl_rd = (valid && !ctrl.illegal) ? rd : '0;
endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID/EX, EX/MEM, MEM/WB control registers with flush and hazard handling.
// Define PIPE_CTRL_LOAD_USE_EN to compile in load-use stall detection; otherwise stall is tied low.
module pipe_ctrl_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 7,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 2
) (
    input logic             clk,
    input logic             rst,
    pipe_ctrl_unit_if.slave bus
);
    ctrl_t           dec, ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
    logic [RA_W-1:0] dec_rd, ex_rd_d, ex_rd_q, mem_rd_d, mem_rd_q, wb_rd_d, wb_rd_q;
    logic            load_use;

    ctrl_decoder #(.OPC_W(OPC_W), .RA_W(RA_W)) u_dec (
        .valid   (bus.id_valid),
        .opcode  (bus.id_opcode),
        .rd      (bus.id_rd),
        .ctrl    (dec),
        .ctrl_rd (dec_rd)
    );

`ifdef PIPE_CTRL_LOAD_USE_EN
    logic [6:0] id_op;
    assign id_op    = 7'(bus.id_opcode);
    assign load_use = bus.id_valid && ex_q.mem_read && (ex_rd_q != '0) &&
                      ((reads_rs1(id_op) && bus.id_rs1 == ex_rd_q) ||
                       (reads_rs2(id_op) && bus.id_rs2 == ex_rd_q));
`else
    assign load_use = 1'b0;
`endif

    // flush outranks the load-use hazard: the dependent instruction is being discarded anyway
    assign bus.stall = load_use && !bus.flush;

    always_comb begin
        ex_d     = (bus.flush || load_use) ? BUBBLE : dec;
        ex_rd_d  = (bus.flush || load_use) ? '0 : dec_rd;
        mem_d    = bus.flush ? BUBBLE : ex_q;
        mem_rd_d = bus.flush ? '0 : ex_rd_q;
        wb_d     = mem_q;
        wb_rd_d  = mem_rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= BUBBLE;
            mem_q    <= BUBBLE;
            wb_q     <= BUBBLE;
            ex_rd_q  <= '0;
            mem_rd_q <= '0;
            wb_rd_q  <= '0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= mem_d;
            wb_q     <= wb_d;
            ex_rd_q  <= ex_rd_d;
            mem_rd_q <= mem_rd_d;
            wb_rd_q  <= wb_rd_d;
        end
    end

    assign bus.ex_alu_src  = ex_q.alu_src;
    assign bus.ex_alu_op   = ALUOP_W'(ex_q.alu_op);
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_illegal  = ex_q.illegal;
    assign bus.mem_read    = mem_q.mem_read;
    assign bus.mem_write   = mem_q.mem_write;
    assign bus.mem_branch  = mem_q.branch;
    assign bus.mem_jump    = mem_q.jump;
    assign bus.wb_regwrite = wb_q.regwrite;
    assign bus.wb_sel      = wb_q.wb_sel;
    assign bus.wb_rd       = wb_rd_q;
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed scoreboard bench; expectations are queued with a due cycle when stimulus is driven.
module tb_pipe_ctrl_unit;
    localparam logic [6:0] T_R = 7'h33, T_I = 7'h13, T_LOAD = 7'h03, T_STORE = 7'h23, T_BR = 7'h63;
    localparam logic [6:0] T_JAL = 7'h6F, T_JALR = 7'h67, T_LUI = 7'h37, T_AUIPC = 7'h17;
    localparam int S_EX = 0, S_MEM = 1, S_WB = 2, S_STALL = 3, S_ALL = 4;

    typedef struct {
        int          due;
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   c = 0;
    int   applied = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit_if #(.OPC_W(7), .RA_W(5), .ALUOP_W(2)) bus ();

    pipe_ctrl_unit dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] obs(input int s);
        logic [8:0] ex;
        logic [3:0] mem;
        logic [7:0] wb;
        ex  = {bus.ex_alu_src, bus.ex_alu_op, bus.ex_rd, bus.ex_illegal};
        mem = {bus.mem_read, bus.mem_write, bus.mem_branch, bus.mem_jump};
        wb  = {bus.wb_regwrite, bus.wb_sel, bus.wb_rd};
        return s == S_EX ? 32'(ex) : s == S_MEM ? 32'(mem) : s == S_WB ? 32'(wb) :
               s == S_STALL ? 32'(bus.stall) : 32'({ex, mem, wb, bus.stall});
    endfunction

    task automatic push(input int due, input string tag, input int sel, input logic [31:0] exp);
        sb.push_back('{due, tag, sel, exp});
    endtask

    task automatic exp_i(input string tag, input int n, input logic src, input logic [1:0] op,
                         input logic [4:0] rd, input logic [3:0] mem, input logic rw, input logic [1:0] sel);
        push(n + 1, {tag, "_ex"}, S_EX, 32'({src, op, rd, 1'b0}));
        push(n + 2, {tag, "_mem"}, S_MEM, 32'(mem));
        push(n + 3, {tag, "_wb"}, S_WB, 32'({rw, sel, rd}));
    endtask

    task automatic check_due();
        logic [31:0] o;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == c) begin
                o = obs(sb[i].sel);
                applied++;
                assert (o === sb[i].exp) else begin
                    fails++;
                    $error("FAIL %s: got %0h, expected %0h (cycle %0d)", sb[i].tag, o, sb[i].exp, c);
                end
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        #1;
        check_due();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rd     = rd;
        bus.id_rs1    = rs1;
        bus.id_rs2    = rs2;
        bus.flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
            push(c, "rst_outputs", S_ALL, 32'd0);
            step();
        end
        rst = 1'b0;

        drive(1, T_R, 5, 1, 2, 0);     exp_i("add",    c, 1'b0, 2'b10, 5'd5, 4'b0000, 1'b1, 2'b00); step();
        drive(1, T_I, 6, 1, 0, 0);     exp_i("addi",   c, 1'b1, 2'b10, 5'd6, 4'b0000, 1'b1, 2'b00); step();
        drive(1, T_LOAD, 7, 1, 0, 0);  exp_i("lw",     c, 1'b1, 2'b00, 5'd7, 4'b1000, 1'b1, 2'b01); step();
        drive(1, T_STORE, 0, 2, 4, 0); exp_i("sw",     c, 1'b1, 2'b00, 5'd0, 4'b0100, 1'b0, 2'b00); step();
        drive(1, T_BR, 0, 1, 2, 0);    exp_i("beq",    c, 1'b0, 2'b01, 5'd0, 4'b0010, 1'b0, 2'b00); step();
        drive(1, T_JAL, 1, 0, 0, 0);   exp_i("jal",    c, 1'b0, 2'b00, 5'd1, 4'b0001, 1'b1, 2'b10); step();
        drive(1, T_JALR, 1, 5, 0, 0);  exp_i("jalr",   c, 1'b1, 2'b00, 5'd1, 4'b0001, 1'b1, 2'b10); step();
        drive(1, T_LUI, 8, 0, 0, 0);   exp_i("lui",    c, 1'b1, 2'b00, 5'd8, 4'b0000, 1'b1, 2'b00); step();
        drive(1, T_AUIPC, 9, 0, 0, 0); exp_i("auipc",  c, 1'b1, 2'b00, 5'd9, 4'b0000, 1'b1, 2'b00); step();
        drive(1, T_R, 0, 1, 2, 0);     exp_i("add_x0", c, 1'b0, 2'b10, 5'd0, 4'b0000, 1'b0, 2'b00); step();
        drive(0, T_R, 12, 1, 2, 0);    exp_i("invalid", c, 1'b0, 2'b00, 5'd0, 4'b0000, 1'b0, 2'b00); step();

        drive(1, 7'h7F, 10, 1, 2, 0);
        push(c + 1, "ill_ex", S_EX, 32'h001);
        push(c + 2, "ill_off", S_EX, 32'h000);
        push(c + 2, "ill_mem", S_MEM, 32'h0);
        push(c + 3, "ill_wb", S_WB, 32'h0);
        step();
        idle(); step();
        idle(); step();

        drive(1, T_LOAD, 3, 1, 0, 0); exp_i("lu_lw", c, 1'b1, 2'b00, 5'd3, 4'b1000, 1'b1, 2'b01); step();
        drive(1, T_R, 4, 3, 2, 0);
`ifdef PIPE_CTRL_LOAD_USE_EN
        push(c, "lu_stall", S_STALL, 32'd1);
        push(c + 1, "lu_bubble", S_EX, 32'd0);
        step();
        push(c, "lu_unstall", S_STALL, 32'd0);
        exp_i("lu_add", c, 1'b0, 2'b10, 5'd4, 4'b0000, 1'b1, 2'b00);
        step();
`else
        push(c, "lu_nostall", S_STALL, 32'd0);
        exp_i("lu_add", c, 1'b0, 2'b10, 5'd4, 4'b0000, 1'b1, 2'b00);
        step();
`endif
        idle(); step();

        drive(1, T_LOAD, 3, 1, 0, 0); step();
        drive(1, T_LUI, 3, 3, 3, 0);
        push(c, "nf_lui_stall", S_STALL, 32'd0);
        exp_i("nf_lui", c, 1'b1, 2'b00, 5'd3, 4'b0000, 1'b1, 2'b00);
        step();
        drive(1, T_LOAD, 0, 1, 0, 0); exp_i("lw_x0", c, 1'b1, 2'b00, 5'd0, 4'b1000, 1'b0, 2'b01); step();
        drive(1, T_R, 4, 0, 0, 0);
        push(c, "nf_x0_stall", S_STALL, 32'd0);
        exp_i("nf_add", c, 1'b0, 2'b10, 5'd4, 4'b0000, 1'b1, 2'b00);
        step();
        idle(); step();

        drive(1, T_STORE, 0, 2, 4, 0); exp_i("fl_sw", c, 1'b1, 2'b00, 5'd0, 4'b0100, 1'b0, 2'b00); step();
        drive(1, T_BR, 0, 1, 2, 0);    exp_i("fl_beq", c, 1'b0, 2'b01, 5'd0, 4'b0010, 1'b0, 2'b00); step();
        drive(1, T_R, 11, 1, 2, 0);    push(c + 1, "fl_add_ex", S_EX, 32'({1'b0, 2'b10, 5'd11, 1'b0})); step();
        drive(1, T_I, 12, 1, 0, 1);
        push(c, "fl_stall", S_STALL, 32'd0);
        push(c + 1, "fl_ex", S_EX, 32'd0);
        push(c + 1, "fl_mem", S_MEM, 32'd0);
        push(c + 2, "fl_wb", S_WB, 32'd0);
        step();
        idle(); step();

        drive(1, T_LOAD, 3, 1, 0, 0); push(c + 1, "sim_lw_ex", S_EX, 32'({1'b1, 2'b00, 5'd3, 1'b0})); step();
        drive(1, T_R, 4, 3, 0, 1);
        push(c, "sim_stall", S_STALL, 32'd0);
        push(c + 1, "sim_ex", S_EX, 32'd0);
        push(c + 1, "sim_mem", S_MEM, 32'd0);
        push(c + 2, "sim_wb", S_WB, 32'd0);
        step();
        idle(); step();

        drive(1, T_R, 13, 1, 2, 0); step();
        drive(1, T_R, 14, 1, 2, 0);
        #2;
        rst = 1'b1;
        push(c, "arst_now", S_ALL, 32'd0);
        step();
        push(c, "arst_hold", S_ALL, 32'd0);
        step();
        rst = 1'b0;
        drive(1, T_I, 15, 1, 0, 0); exp_i("post_rst", c, 1'b1, 2'b10, 5'd15, 4'b0000, 1'b1, 2'b00); step();
        idle();
        repeat (4) step();

        if (sb.size() != 0) begin
            fails += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations never checked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end
endmodule
